// File: rtl/cpu_shift_pkg.sv
// rtl/cpu_shift_pkg.sv - shared op/state encodings and widths for serial_shifter
package cpu_shift_pkg;

    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_AMT_W = 5;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single shift step (by 1, or by 4 when stride4 is set)
module shift_step
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic             stride4,
    output logic [WIDTH-1:0] next_value
);

    // Op 2'b10 is not a real encoding and deliberately falls through to SLL.
    always_comb begin
        next_value = value;
        case (op)
            SHIFT_SRL: next_value = stride4 ? {4'b0000, value[WIDTH-1:4]}
                                            : {1'b0, value[WIDTH-1:1]};
            SHIFT_SRA: next_value = stride4 ? {{4{sign}}, value[WIDTH-1:4]}
                                            : {sign, value[WIDTH-1:1]};
            default:   next_value = stride4 ? {value[WIDTH-5:0], 4'b0000}
                                            : {value[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - multi-cycle SLL/SRL/SRA unit; SERIAL_SHIFTER_STRIDE4_EN enables 4-bit strides
module serial_shifter
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int AMT_W = SHIFT_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    shift_state_e     state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic             stride4;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] step_value;

    // Only the low AMT_W bits of the shift amount are architecturally meaningful.
    logic unused_amt_hi;
    assign unused_amt_hi = ^amt[WIDTH-1:AMT_W];

`ifdef SERIAL_SHIFTER_STRIDE4_EN
    assign stride4 = (cnt_q >= AMT_W'(4));
`else
    assign stride4 = 1'b0;
`endif
    assign step_amt = stride4 ? AMT_W'(4) : AMT_W'(1);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value      (result_q),
        .op         (op_q),
        .sign       (sign_q),
        .stride4    (stride4),
        .next_value (step_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            op_q     <= SHIFT_SLL;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        sign_d   = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = data_in;
                    cnt_d    = amt[AMT_W-1:0];
                    op_d     = op;
                    sign_d   = data_in[WIDTH-1];
                    state_d  = (amt[AMT_W-1:0] == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                result_d = step_value;
                cnt_d    = cnt_q - step_amt;
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode directly from flops, so nothing on an input reaches an output combinationally.
    assign result = result_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: doc/serial_shifter.md
# serial_shifter

Multi-cycle shift unit for the CPU datapath. It executes SLL/SRL/SRA and their variable forms by one bit per clock. It is the consuming end of the 32-bit shift-amount operand: it narrows the operand back to its low 5 bits and shifts under a start/busy/done handshake. It sits beside the ALU in the execute stage; the controller stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: data width; fixed at 32 for this CPU.
- `AMT_W`, 5: shift-count width, log2(`WIDTH`).
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 SLL, 01 SRL, 11 SRA, 10 treated as SLL.
- `data_in`  in  32  value to shift.
- `amt`  in  32  shift amount; only `amt[4:0]` used, `amt[31:5]` ignored.
- `result`  out  32  shifted value, registered.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse, result valid.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: shifting.
  - DONE: single-cycle completion.
- IDLE with `start`=1:
  - load `result`<=`data_in`, `cnt`<=`amt[4:0]`, latch `op`, latch sign = `data_in[31]`.
  - next state is DONE if `cnt`==0, else SHIFT.
- SHIFT, one step per clock:
  - SLL: `result`<={`result[30:0]`,0}.
  - SRL: `result`<={0,`result[31:1]`}.
  - SRA: `result`<={sign,`result[31:1]`}.
  - `cnt`<=`cnt`-1; when `cnt`==1 (last step), next state is DONE.
- DONE: `done`=1 for exactly one cycle, then unconditional return to IDLE.
- `result` holds its final value after DONE until the next accepted `start`. `result` is not meaningful while in SHIFT.
- `start` is ignored in SHIFT and DONE, so there is no queueing. The requester must hold or reissue it.
- Inputs are sampled only at the accept edge; later changes to `data_in`/`amt`/`op` have no effect.
- Reset mid-operation: immediate return to IDLE, `result`=0, `busy`=0, `done`=0, `cnt`=0. The in-flight request is discarded.

## Timing
- Reset values: `result`=32'h0, `busy`=0, `done`=0, state IDLE.
- Cycle counting: the cycle in which `start` is accepted is cycle 0.
- With k = `amt[4:0]`, `done` is high in cycle k+1.
  - k=0: `done` in cycle 1.
  - k=31: `done` in cycle 32.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Minimum spacing between accepted starts is k+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SHIFTER_STRIDE4_EN` defined:
  - in SHIFT, a step with `cnt`>=4 shifts by 4 (SRA fills 4 sign bits) and sets `cnt`-=4; otherwise it shifts by 1.
  - DONE is entered after the step that brings `cnt` to 0.
  - Steps s = k/4 + k%4 (integer division); `done` is high in cycle s+1, so k=31 gives cycle 11.
- Macro undefined: strictly one bit per cycle, exactly as above.
- The handshake, reset behaviour and results are identical in both builds; only latency differs.

## Structure
- Package `cpu_shift_pkg`:
  - op encodings `SHIFT_SLL`/`SHIFT_SRL`/`SHIFT_SRA`.
  - state encoding IDLE/SHIFT/DONE.
  - constants `SHIFT_WIDTH`=32 and `SHIFT_AMT_W`=5.
- Sub-module `shift_step`: purely combinational single step (by 1, or by 4 when stride is selected) taking value, op, sign and stride select.
- Top level holds the FSM, `cnt`, the `result` register and the handshake.

## Test plan
- SLL, `data_in`=32'h0000_0001, `amt`=32'h1F -> `result`=32'h8000_0000, `done` in cycle 32, `busy` high cycles 1–32.
- SRA then SRL, `data_in`=32'h8000_0000, `amt`=4 -> 32'hF800_0000, then 32'h0800_0000; `done` in cycle 5 each.
- `amt`=32'hFFFF_FFE0 (low bits 0), `data_in`=32'h1234_5678 -> `result`=32'h1234_5678, `done` in cycle 1; upper amt bits ignored.
- `start` pulsed with new data during SHIFT and during DONE -> ignored; original result delivered; a subsequent IDLE start is accepted.
- `rst` asserted mid-SHIFT -> `result`=0, `busy`=0, `done`=0 immediately; the next request completes correctly.
- With `SERIAL_SHIFTER_STRIDE4_EN`: SRL, `data_in`=32'hF000_0000, `amt`=9 -> 32'h0078_0000, `done` in cycle 4; without the macro, `done` in cycle 10.
